dot_product_accumulator: RTL and testbench

Sequential stage directly downstream of `singlecycle_multiplier`. It consumes a stream of 2N-bit products from the multiplier's `result` output and sums LEN consecutive accepted products into one dot-product value. The finished sum is presented on a valid/ready output port. Together with the combinational multiplier, it forms a vector dot-product datapath.

---
 rtl/dot_product_accumulator.sv | 116 +++++++++++
 tb/tb_dot_product_accumulator.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator
//
// Sums LEN consecutive accepted 2N-bit unsigned products (the output of the
// upstream combinational multiplier) into one ACC_W-bit dot product. The
// finished value is offered on a valid/ready port. While it waits there, no
// new products are accepted.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-high reset; discards everything,
//                including a pending sum
//   clear      - synchronous abort of a partial accumulation; has no effect
//                while a completed sum is pending
//   in_valid   - product is valid this cycle
//   in_ready   - block accepts a product this cycle
//   product    - unsigned product, 2N bits
//   out_valid  - sum holds a completed dot product
//   out_ready  - downstream consumes sum this cycle
//   sum        - completed dot product, ACC_W bits
//   count      - products accepted in the current accumulation
module dot_product_accumulator #(
    parameter int N     = 8,
    parameter int LEN   = 4,
    parameter int ACC_W = 2 * N + $clog2(LEN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*N-1:0]           product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         sum,
    output logic [$clog2(LEN):0]     count
);

    localparam int CW = $clog2(LEN) + 1;

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    localparam logic [CW-1:0] LAST_COUNT = CW'(LEN - 1);

    logic [0:0]       state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [ACC_W-1:0] sum_reg, sum_next;

    logic             accept;
    logic [ACC_W-1:0] acc_plus;

    // in_ready depends only on registered state and clear, so there is no
    // combinational path from in_valid or out_ready.
    assign in_ready  = (state_reg == ACCUM) && !clear;
    assign out_valid = (state_reg == HOLD);
    assign sum       = sum_reg;
    assign count     = count_reg;

    assign accept   = in_valid && in_ready;
    assign acc_plus = acc_reg + ACC_W'(product);

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        sum_next   = sum_reg;

        case (state_reg)
            ACCUM: begin
                if (clear) begin
                    acc_next   = '0;
                    count_next = '0;
                end else if (accept) begin
                    if (count_reg == LAST_COUNT) begin
                        // The LEN-th product closes the dot product. The
                        // accumulator restarts so the next vector begins
                        // cleanly after the handshake.
                        sum_next   = acc_plus;
                        acc_next   = '0;
                        count_next = '0;
                        state_next = HOLD;
                    end else begin
                        acc_next   = acc_plus;
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            HOLD: begin
                // clear is deliberately ignored here. A completed sum is
                // only released by the downstream handshake or by reset.
                if (out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ACCUM;
            acc_reg   <= '0;
            count_reg <= '0;
            sum_reg   <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            sum_reg   <= sum_next;
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Testbench for dot_product_accumulator (N=8, LEN=4, ACC_W=18).
// Stimulus pushes each expected sum into a queue. A monitor on the falling
// edge pops and compares the queue whenever a valid/ready handshake is
// presented. Direct checks cover control outputs and hold behaviour.
module tb_dot_product_accumulator;

    localparam int N     = 8;
    localparam int LEN   = 4;
    localparam int ACC_W = 18;
    localparam int CW    = $clog2(LEN) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   product;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] sum;
    logic [CW-1:0]    count;

    int total = 0;
    int bad   = 0;

    logic [ACC_W-1:0] exp_q[$];
    logic [ACC_W-1:0] mon_exp;

    always #5 clk = ~clk;

    dot_product_accumulator #(
        .N     (N),
        .LEN   (LEN),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .count     (count)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one product for one cycle, then drop in_valid.
    task automatic feed(input int v);
        in_valid = 1'b1;
        product  = 16'(v);
        step();
        in_valid = 1'b0;
    endtask

    // Monitor: a handshake is visible at the falling edge and completes on
    // the following rising edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got sum=%0d expected no result", sum);
            end else begin
                mon_exp = exp_q.pop_front();
                if (sum != mon_exp) begin
                    bad++;
                    $display("FAIL result_sum: got %0d expected %0d", sum, mon_exp);
                end else begin
                    $display("result sum=%0d ok", sum);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        product   = '0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_sum", sum, 0);

        // Basic sum: 4 x 49 back to back
        exp_q.push_back(18'd196);
        in_valid = 1'b1;
        product  = 16'd49;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i < 3) check("basic_count", count, i + 1);
        end
        in_valid = 1'b0;
        check("basic_out_valid", out_valid, 1);
        check("basic_in_ready_hold", in_ready, 0);
        check("basic_count_zero", count, 0);
        step();
        check("basic_one_cycle", out_valid, 0);
        check("basic_in_ready_back", in_ready, 1);

        // Max values: 4 x 65025
        exp_q.push_back(18'd260100);
        in_valid = 1'b1;
        product  = 16'd65025;
        for (int i = 0; i < 4; i++) step();
        in_valid = 1'b0;
        check("max_sum", sum, 260100);
        step();

        // Gaps and backpressure
        out_ready = 1'b0;
        exp_q.push_back(18'd10);
        for (int i = 1; i <= 4; i++) begin
            feed(i);
            if (i < 4) step();
        end
        check("gap_out_valid", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_sum", sum, 10);
        end
        out_ready = 1'b1;
        step();
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);

        // Clear mid-accumulation
        feed(100);
        feed(200);
        check("clr_count2", count, 2);
        clear    = 1'b1;
        in_valid = 1'b1;
        product  = 16'd999;
        #1;
        check("clr_in_ready", in_ready, 0);
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_count0", count, 0);
        exp_q.push_back(18'd4);
        for (int i = 0; i < 4; i++) feed(1);
        check("clr_sum", sum, 4);
        step();

        // Reset mid-operation
        for (int i = 0; i < 3; i++) feed(7);
        check("rmid_count3", count, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rmid_count0", count, 0);
        check("rmid_out_valid", out_valid, 0);
        exp_q.push_back(18'd28);
        for (int i = 0; i < 4; i++) feed(7);
        check("rmid_sum", sum, 28);
        step();

        // Clear and reset while a sum is pending (this sum is discarded by
        // reset, so it is not queued for the monitor)
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed(49);
        check("hold_out_valid", out_valid, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("hold_clr_valid", out_valid, 1);
        check("hold_clr_sum", sum, 196);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("hold_rst_valid", out_valid, 0);
        check("hold_rst_sum", sum, 0);
        out_ready = 1'b1;
        step();

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
